// File: rtl/mm_pkg.sv
// Shared types and width helpers for the matrix-multiply controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mm_pkg;

  // Compute-side FSM: clear the array, stream operands in, wait for results.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_COMPUTE = 2'd3
  } mm_state_e;

  // Width of one C element: a full-precision product plus growth for N accumulations.
  function automatic int c_width(input int data_width, input int n);
    return 2 * data_width + $clog2(n);
  endfunction

endpackage

// File: rtl/mm_result_buffer.sv
// Holds one captured N x N result and drains it row by row over valid/ready.
// Latency: capture visible on res_valid_o the cycle after capture_i.
// Backpressure: row and index hold while res_ready_i=0; capture allowed only when empty or on the last-row handshake.
module mm_result_buffer
  import mm_pkg::*;
#(
  parameter int N            = 4,
  parameter int C_DATA_WIDTH = 18,
  parameter int IDX_W        = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_i,
  input  logic                                 capture_i,
  input  logic [N*N-1:0][C_DATA_WIDTH-1:0]     c_i,
  output logic                                 cap_ok_o,
  output logic                                 res_valid_o,
  input  logic                                 res_ready_i,
  output logic [N-1:0][C_DATA_WIDTH-1:0]       res_row_o,
  output logic [IDX_W-1:0]                     res_idx_o,
  output logic                                 res_last_o,
  output logic                                 done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic                    full_q, full_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [C_DATA_WIDTH-1:0] data_q [N][N];
  logic [C_DATA_WIDTH-1:0] data_d [N][N];
  logic                    hs;
  logic                    last_hs;

  // Outputs are forced to their idle values while reset is held.
  assign res_valid_o = full_q && !reset_i;
  assign res_idx_o   = reset_i ? '0 : idx_q;
  assign res_last_o  = (res_idx_o == LAST_IDX);
  assign hs          = res_valid_o && res_ready_i;
  assign last_hs     = hs && (idx_q == LAST_IDX);
  assign done_o      = last_hs;
  // The slot frees up in the same cycle the final row leaves.
  assign cap_ok_o    = !full_q || last_hs;

  // Present the row currently addressed by the read index.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      res_row_o[j] = data_q[idx_q][j];
    end
  end

  // Next-state for fill flag, read index and storage; a capture overrides the drain.
  always_comb begin
    full_d = full_q;
    idx_d  = idx_q;
    data_d = data_q;
    if (hs) begin
      if (idx_q == LAST_IDX) begin
        full_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (capture_i) begin
      full_d = 1'b1;
      idx_d  = '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          data_d[i][j] = c_i[i*N + j];
        end
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      full_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      full_q <= full_d;
      idx_q  <= idx_d;
    end
  end

  // Result storage; contents are qualified by full_q so they need no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/mm_controller.sv
// Sequences a systolic array through clear/load/compute and drains C by rows.
// Latency: start at t with contiguous beats -> array valid at t+3N, res_valid_o at t+3N+1.
// Backpressure: op_ready_o only in LOAD; a full buffer holds COMPUTE until the last row leaves.
module mm_controller
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int N            = 4,
  parameter int C_DATA_WIDTH = c_width(DATA_WIDTH, N),
  parameter int TIMEOUT      = 2*N + 2
) (
  input  logic                                 clk,
  input  logic                                 reset_i,
  input  logic                                 start_i,
  output logic                                 busy_o,
  input  logic                                 op_valid_i,
  output logic                                 op_ready_o,
  input  logic [N-1:0][DATA_WIDTH-1:0]         op_a_i,
  input  logic [N-1:0][DATA_WIDTH-1:0]         op_b_i,
  output logic                                 arr_reset_o,
  output logic                                 arr_valid_o,
  output logic [N-1:0][DATA_WIDTH-1:0]         arr_a_o,
  output logic [N-1:0][DATA_WIDTH-1:0]         arr_b_o,
  input  logic                                 arr_valid_i,
  input  logic [N*N-1:0][C_DATA_WIDTH-1:0]     arr_c_i,
  output logic                                 res_valid_o,
  input  logic                                 res_ready_i,
  output logic [N-1:0][C_DATA_WIDTH-1:0]       res_row_o,
  output logic [$clog2(N)-1:0]                 res_idx_o,
  output logic                                 res_last_o,
  output logic                                 done_o,
  output logic                                 err_o
);

  localparam int IDX_W = $clog2(N);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(N - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  mm_state_e        state_q, state_d;
  logic [IDX_W-1:0] beat_q, beat_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             capture;
  logic             cap_ok;
  logic             in_load;

  assign in_load     = (state_q == ST_LOAD);
  assign busy_o      = (state_q != ST_IDLE) && !reset_i;
  assign op_ready_o  = in_load && !reset_i;
  assign err_o       = err_q && !reset_i;
  // Operands pass straight through to the array only while loading.
  assign arr_valid_o = op_ready_o && op_valid_i;
  assign arr_a_o     = in_load ? op_a_i : '0;
  assign arr_b_o     = in_load ? op_b_i : '0;
  assign arr_reset_o = reset_i || (state_q == ST_CLEAR);

  // Next-state logic: beat counting in LOAD, capture or timeout in COMPUTE.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        beat_d  = '0;
        tmo_d   = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (op_valid_i) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_COMPUTE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        if (arr_valid_i) begin
          // Results ready: take them if the buffer can, otherwise hold
          // without counting towards the timeout.
          if (cap_ok) begin
            capture = 1'b1;
            tmo_d   = '0;
            state_d = ST_IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  mm_result_buffer #(
    .N            (N),
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .IDX_W        (IDX_W)
  ) u_buf (
    .clk         (clk),
    .reset_i     (reset_i),
    .capture_i   (capture),
    .c_i         (arr_c_i),
    .cap_ok_o    (cap_ok),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_row_o   (res_row_o),
    .res_idx_o   (res_idx_o),
    .res_last_o  (res_last_o),
    .done_o      (done_o)
  );

endmodule

// File: tb/tb_mm_controller.sv
// Self-checking bench for mm_controller with a behavioural systolic-array stand-in.
// Latency: checks first result at start+3N+1 and timeout after TIMEOUT compute cycles.
// Backpressure: exercises random and long result stalls, including a held second job.
module tb_mm_controller;

  localparam int DW  = 8;
  localparam int N   = 4;
  localparam int CW  = 2*DW + $clog2(N);
  localparam int TMO = 2*N + 2;

  typedef int imat_t [N][N];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset_i = 1'b1;
  logic                      start_i = 1'b0;
  logic                      busy_o;
  logic                      op_valid_i = 1'b0;
  logic                      op_ready_o;
  logic [N-1:0][DW-1:0]      op_a_i = '0;
  logic [N-1:0][DW-1:0]      op_b_i = '0;
  logic                      arr_reset_o;
  logic                      arr_valid_o;
  logic [N-1:0][DW-1:0]      arr_a_o;
  logic [N-1:0][DW-1:0]      arr_b_o;
  logic                      arr_valid_i;
  logic [N*N-1:0][CW-1:0]    arr_c_i;
  logic                      res_valid_o;
  logic                      res_ready_i = 1'b0;
  logic [N-1:0][CW-1:0]      res_row_o;
  logic [$clog2(N)-1:0]      res_idx_o;
  logic                      res_last_o;
  logic                      done_o;
  logic                      err_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit arr_dead = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  mm_controller #(.DATA_WIDTH(DW), .N(N), .C_DATA_WIDTH(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_i(reset_i), .start_i(start_i), .busy_o(busy_o),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .arr_reset_o(arr_reset_o), .arr_valid_o(arr_valid_o), .arr_a_o(arr_a_o), .arr_b_o(arr_b_o),
    .arr_valid_i(arr_valid_i), .arr_c_i(arr_c_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_row_o(res_row_o),
    .res_idx_o(res_idx_o), .res_last_o(res_last_o), .done_o(done_o), .err_o(err_o)
  );

  // Array stand-in: accumulates outer products of accepted beats, raises valid
  // 2N-1 cycles after the last beat and holds it until the next array reset.
  logic [CW-1:0] acc [N][N];
  int            beats;
  int            since;
  logic          arr_vld;

  always @(posedge clk) begin
    if (arr_reset_o) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) acc[i][j] <= '0;
      beats   <= 0;
      since   <= 0;
      arr_vld <= 1'b0;
    end else begin
      if (arr_valid_o) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            acc[i][j] <= acc[i][j] + CW'(arr_a_o[i]) * CW'(arr_b_o[j]);
        beats <= beats + 1;
      end
      if (beats == N) begin
        since <= since + 1;
        if (since == 2*N - 3 && !arr_dead) arr_vld <= 1'b1;
      end
    end
  end

  assign arr_valid_i = arr_vld;
  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) arr_c_i[i*N + j] = acc[i][j];
  end

  // ---------------- reference model helpers ----------------
  function automatic void matmul(input imat_t a, input imat_t b, output imat_t c);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c[i][j] = 0;
        for (int k = 0; k < N; k++) c[i][j] += a[i][k] * b[k][j];
      end
  endfunction

  function automatic void fill_mat(input int kind, output imat_t m);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        case (kind)
          0: m[i][j] = (i == j) ? 1 : 0;
          1: m[i][j] = 255;
          default: m[i][j] = int'($urandom_range(0, 255));
        endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a job: start pulse, then N beats (column k of A, row k of B),
  // with an optional idle gap of gaplen cycles before beats gap0 and gap1.
  task automatic send_job(input imat_t a, input imat_t b, input int gap0, input int gap1,
                          input int gaplen, output int t0);
    int guard;
    t0 = cyc;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == gap0 || k == gap1) begin
        op_valid_i = 1'b0;
        repeat (gaplen) tick();
      end
      for (int i = 0; i < N; i++) begin
        op_a_i[i] = DW'(a[i][k]);
        op_b_i[i] = DW'(b[k][i]);
      end
      op_valid_i = 1'b1;
      if (k == 0) begin
        #1;
        total++;
        if (arr_reset_o !== 1'b1 || arr_valid_o !== 1'b0 || arr_a_o !== '0 || busy_o !== 1'b1) begin
          bad++;
          $display("FAIL clear_cycle: arr_reset=%b arr_valid=%b arr_a=%h busy=%b want 1 0 0 1",
                   arr_reset_o, arr_valid_o, arr_a_o, busy_o);
        end
      end
      guard = 0;
      while (!op_ready_o && guard < 20) begin
        tick();
        guard++;
      end
      if (guard >= 20) begin
        total++;
        bad++;
        $display("FAIL beat_wait: op_ready stayed %b, want 1", op_ready_o);
      end
      tick();
    end
    op_valid_i = 1'b0;
    op_a_i = '0;
    op_b_i = '0;
  endtask

  task automatic wait_valid(output int tv);
    int guard = 0;
    while (!res_valid_o && guard < 200) begin
      tick();
      guard++;
    end
    tv = cyc;
    if (guard >= 200) begin
      total++;
      bad++;
      $display("FAIL res_wait: res_valid stayed %b, want 1", res_valid_o);
    end
  endtask

  // Drain all N rows and compare each against the expected product.
  task automatic drain(input imat_t e, input bit bp, input string nm);
    logic [N-1:0][CW-1:0] er;
    int guard;
    int stalls;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) er[j] = CW'(e[r][j]);
      guard = 0;
      while (!res_valid_o && guard < 200) begin
        tick();
        guard++;
      end
      if (guard >= 200) begin
        total++;
        bad++;
        $display("FAIL %s row_wait: res_valid=%b want 1", nm, res_valid_o);
        res_ready_i = 1'b0;
        return;
      end
      stalls = bp ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s < stalls; s++) begin
        res_ready_i = 1'b0;
        #1;
        total++;
        if (res_row_o !== er || res_idx_o !== 2'(r)) begin
          bad++;
          $display("FAIL %s stall_hold r%0d: row=%h idx=%0d want %h %0d", nm, r, res_row_o, res_idx_o, er, r);
        end
        tick();
      end
      res_ready_i = 1'b1;
      #1;
      total++;
      if (res_row_o !== er) begin
        bad++;
        $display("FAIL %s row%0d data: got %h want %h", nm, r, res_row_o, er);
      end
      total++;
      if (res_idx_o !== 2'(r) || res_last_o !== (r == N-1) || done_o !== (r == N-1)) begin
        bad++;
        $display("FAIL %s row%0d flags: idx=%0d last=%b done=%b want %0d %b %b",
                 nm, r, res_idx_o, res_last_o, done_o, r, (r == N-1), (r == N-1));
      end
      tick();
    end
    res_ready_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset_i = 1'b1;
    tick();
    tick();
    total++;
    if (busy_o !== 1'b0 || op_ready_o !== 1'b0 || res_valid_o !== 1'b0 || done_o !== 1'b0 ||
        err_o !== 1'b0 || res_idx_o !== '0 || arr_reset_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: busy=%b rdy=%b rv=%b done=%b err=%b idx=%0d arst=%b want 0 0 0 0 0 0 1",
               busy_o, op_ready_o, res_valid_o, done_o, err_o, res_idx_o, arr_reset_o);
    end
    reset_i = 1'b0;
    tick();
    total++;
    if (arr_reset_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: arst=%b busy=%b want 0 0", arr_reset_o, busy_o);
    end
  endtask

  task automatic test_identity;
    imat_t a, e;
    int t0, tv;
    fill_mat(0, a);
    matmul(a, a, e);
    send_job(a, a, -1, -1, 0, t0);
    wait_valid(tv);
    total++;
    if (tv - t0 !== 3*N + 1) begin
      bad++;
      $display("FAIL ident_latency: got %0d want %0d", tv - t0, 3*N + 1);
    end
    drain(e, 1'b0, "ident");
  endtask

  task automatic test_max;
    imat_t a, e;
    int t0, tv;
    fill_mat(1, a);
    matmul(a, a, e);
    send_job(a, a, -1, -1, 0, t0);
    wait_valid(tv);
    total++;
    if (e[0][0] !== 260100) begin
      bad++;
      $display("FAIL max_model: got %0d want 260100", e[0][0]);
    end
    drain(e, 1'b1, "max");
  endtask

  task automatic test_random;
    imat_t a, b, e;
    int t0, tv;
    for (int n = 0; n < 3; n++) begin
      fill_mat(2, a);
      fill_mat(2, b);
      matmul(a, b, e);
      send_job(a, b, -1, -1, 0, t0);
      wait_valid(tv);
      drain(e, 1'b1, "random");
    end
  endtask

  task automatic test_gaps;
    imat_t a, e;
    int t0, tv;
    fill_mat(0, a);
    matmul(a, a, e);
    send_job(a, a, 1, 3, 2, t0);
    wait_valid(tv);
    total++;
    if (tv - t0 !== 3*N + 5) begin
      bad++;
      $display("FAIL gap_latency: got %0d want %0d", tv - t0, 3*N + 5);
    end
    drain(e, 1'b1, "gaps");
  endtask

  task automatic test_back_to_back;
    imat_t a1, b1, e1, a2, b2, e2;
    int t0, t1, tv;
    fill_mat(2, a1); fill_mat(2, b1); matmul(a1, b1, e1);
    fill_mat(2, a2); fill_mat(2, b2); matmul(a2, b2, e2);
    res_ready_i = 1'b0;
    send_job(a1, b1, -1, -1, 0, t0);
    wait_valid(tv);
    send_job(a2, b2, -1, -1, 0, t1);
    repeat (3*N) tick();
    total++;
    if (busy_o !== 1'b1 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_hold: busy=%b err=%b want 1 0", busy_o, err_o);
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    drain(e1, 1'b0, "b2b_job1");
    total++;
    if (busy_o !== 1'b0 || res_valid_o !== 1'b1 || res_idx_o !== '0) begin
      bad++;
      $display("FAIL b2b_capture: busy=%b rv=%b idx=%0d want 0 1 0", busy_o, res_valid_o, res_idx_o);
    end
    tick();
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_no_queue: busy=%b want 0", busy_o);
    end
    drain(e2, 1'b1, "b2b_job2");
  endtask

  task automatic test_timeout;
    imat_t a;
    int t0;
    fill_mat(2, a);
    arr_dead = 1'b1;
    send_job(a, a, -1, -1, 0, t0);
    while (cyc < t0 + N + 1 + TMO) tick();
    total++;
    if (busy_o !== 1'b1 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL tmo_before: busy=%b err=%b want 1 0", busy_o, err_o);
    end
    tick();
    total++;
    if (busy_o !== 1'b0 || err_o !== 1'b1 || res_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL tmo_fire: busy=%b err=%b rv=%b want 0 1 0", busy_o, err_o, res_valid_o);
    end
    tick();
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL tmo_sticky: err=%b want 1", err_o);
    end
    arr_dead = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL tmo_clear: err=%b want 0", err_o);
    end
  endtask

  task automatic test_reset_mid;
    imat_t a, b, e;
    int t0, tv;
    fill_mat(2, a); fill_mat(2, b);
    send_job(a, b, -1, -1, 0, t0);
    wait_valid(tv);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    op_valid_i = 1'b1;
    op_a_i = {N{8'h11}};
    op_b_i = {N{8'h22}};
    tick();
    tick();
    tick();
    reset_i = 1'b1;
    #1;
    total++;
    if (busy_o !== 1'b0 || op_ready_o !== 1'b0 || arr_valid_o !== 1'b0 || res_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL midrst_hold: busy=%b rdy=%b av=%b rv=%b want 0 0 0 0", busy_o, op_ready_o, arr_valid_o, res_valid_o);
    end
    tick();
    reset_i = 1'b0;
    op_valid_i = 1'b0;
    op_a_i = '0;
    op_b_i = '0;
    #1;
    total++;
    if (busy_o !== 1'b0 || op_ready_o !== 1'b0 || res_valid_o !== 1'b0 || res_idx_o !== '0 ||
        err_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state: busy=%b rdy=%b rv=%b idx=%0d err=%b done=%b want all 0",
               busy_o, op_ready_o, res_valid_o, res_idx_o, err_o, done_o);
    end
    tick();
    fill_mat(2, a); fill_mat(2, b); matmul(a, b, e);
    send_job(a, b, -1, -1, 0, t0);
    wait_valid(tv);
    total++;
    if (tv - t0 !== 3*N + 1) begin
      bad++;
      $display("FAIL midrst_latency: got %0d want %0d", tv - t0, 3*N + 1);
    end
    drain(e, 1'b1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_max();
    test_random();
    test_gaps();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mm_controller.md
MM_CONTROLLER -- requirements
Module: mm_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand element width.
REQ-002 SHALL have parameter N, default 4, matrix dimension.
REQ-003 SHALL have parameter C_DATA_WIDTH, default 2*DATA_WIDTH+$clog2(N), result element width.
REQ-004 SHALL have parameter TIMEOUT, default 2*N+2, the maximum number of COMPUTE cycles spent waiting for the array.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 reset_i  in  1  reset; synchronous, active-high.
REQ-007 start_i  in  1  job request; sampled only in IDLE.
REQ-008 busy_o  out  1  high whenever the compute FSM is not IDLE.
REQ-009 op_valid_i / op_ready_o  in / out  1 / 1  operand beat handshake.
REQ-010 op_a_i / op_b_i  in  DATA_WIDTH x N each  beat k carries column k of A and row k of B.
REQ-011 arr_reset_o  out  1  reset to the systolic array.
REQ-012 arr_valid_o  out  1  array valid input.
REQ-013 arr_a_o / arr_b_o  out  DATA_WIDTH x N each  array operand inputs.
REQ-014 arr_valid_i  in  1  array valid output; high and held until array reset.
REQ-015 arr_c_i  in  C_DATA_WIDTH x N*N  array results, row-major.
REQ-016 res_valid_o / res_ready_i  out / in  1 / 1  result row handshake.
REQ-017 res_row_o  out  C_DATA_WIDTH x N  one row of C.
REQ-018 res_idx_o  out  $clog2(N)  row index; res_last_o  out  1  high when res_idx_o==N-1.
REQ-019 done_o  out  1  one-cycle pulse on the last-row handshake.
REQ-020 err_o  out  1  sticky timeout flag.

Function
REQ-021 Compute FSM states SHALL be IDLE, CLEAR, LOAD, COMPUTE.
REQ-022 IDLE->CLEAR on start_i; start_i outside IDLE SHALL be ignored (no queuing).
REQ-023 CLEAR SHALL last exactly 1 cycle with arr_reset_o=1, then go to LOAD.
REQ-024 In LOAD: op_ready_o=1; arr_valid_o=op_valid_i; arr_a_o/arr_b_o=op_a_i/op_b_i combinationally; arr_a_o/arr_b_o=0 outside LOAD.
REQ-025 LOAD SHALL count accepted beats; gaps in op_valid_i stall the count (the array stalls too); after beat N-1 is accepted, go to COMPUTE.
REQ-026 In COMPUTE: when arr_valid_i=1 and the buffer is capturable, copy all N*N arr_c_i into the result buffer and go to IDLE.
REQ-027 Buffer capturable SHALL mean buf_full=0, or a last-row handshake occurring in the same cycle; in that case the new capture wins and buf_full stays 1 with res_idx_o reset to 0.
REQ-028 If arr_valid_i=1 but the buffer is not capturable, COMPUTE SHALL hold (the array keeps its results) and the timeout counter SHALL not advance.
REQ-029 The timeout counter SHALL count COMPUTE cycles with arr_valid_i=0; on reaching TIMEOUT: err_o<=1, FSM->IDLE, no capture.
REQ-030 Drain: res_valid_o=buf_full; res_row_o=buffer row res_idx_o; res_idx_o advances on each handshake; the last-row handshake clears buf_full (unless REQ-027 applies), pulses done_o, and resets res_idx_o to 0.
REQ-031 res_row_o SHALL remain stable while res_valid_o=1 and res_ready_i=0.
REQ-032 Drain and compute SHALL run concurrently: a new job may proceed through CLEAR/LOAD/COMPUTE while the previous result drains.
REQ-033 Latency: start_i at cycle t with contiguous beats gives arr_valid_i at t+3N and res_valid_o at t+3N+1.

Reset
REQ-034 On reset_i, the following SHALL be held while reset_i=1: FSM=IDLE, beat and timeout counters=0, buf_full=0, res_idx_o=0, err_o=0, busy_o=0, op_ready_o=0, res_valid_o=0, done_o=0.
REQ-035 arr_reset_o SHALL equal reset_i OR (state==CLEAR).
REQ-036 Reset mid-job SHALL discard the job and any buffered result; buffer data contents need not be cleared.

Structure
REQ-037 Package mm_pkg SHALL hold the compute-state enum and the C width helper function.
REQ-038 Sub-module mm_result_buffer SHALL hold the N*N capture registers, buf_full, and the row read-out/index logic.

Verification
REQ-039 N=4, A=B=identity, start at cycle 0, contiguous beats: res_valid_o first at cycle 13; rows are identity; done_o pulses on row 3.
REQ-040 A=all 255, B=all 255: every element = 260100, which fits C_DATA_WIDTH=18.
REQ-041 Two op_valid_i gaps of 2 cycles each during LOAD: results identical to REQ-039, res_valid_o 4 cycles later.
REQ-042 res_ready_i=0 on the first job and a second job started: second job holds in COMPUTE; on release, rows 0..3 of job 1 stream and job 2 captures on the last-row cycle.
REQ-043 arr_valid_i tied 0: err_o=1 after 10 COMPUTE cycles; FSM returns to IDLE; busy_o=0.
REQ-044 reset_i during LOAD beat 2: all outputs match REQ-034 next cycle; a subsequent job is correct.
